// File: rtl/occupancy_counter.sv
// Saturating room-occupancy counter with capacity alarm, sticky error flags
// and a sequential double-dabble converter feeding the 3-digit display.
module occupancy_counter #(
  parameter int CNT_W        = 8,
  parameter int CAPACITY     = 99,
  parameter int ALARM_CYCLES = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sumar,
  input  logic             restar,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             alarm,
  output logic             err_under,
  output logic             err_over,
  output logic [3:0]       bcd_hund,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             bcd_valid
);

  localparam int AW = $clog2(ALARM_CYCLES + 1);
  localparam int BW = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  localparam logic [AW-1:0]    ALD = AW'(ALARM_CYCLES);
  localparam logic [BW-1:0]    LST = BW'(CNT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  logic [CNT_W-1:0] r_count;
  logic [AW-1:0]    r_alarm_tmr;
  logic             r_err_under;
  logic             r_err_over;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_snap;
  logic [CNT_W-1:0] r_shreg;
  logic [11:0]      r_scr;
  logic [BW-1:0]    r_bit_cnt;
  logic [CNT_W-1:0] r_last;
  logic             r_pending;
  logic [3:0]       r_hund;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic             r_valid;

  logic             w_inc;
  logic             w_dec;
  logic             w_over;
  logic             w_under;
  logic             w_chg;
  logic             w_start;
  logic             w_last;
  logic             w_load;
  logic             w_shift;
  logic             w_done;
  logic [11:0]      w_adj;

  assign w_inc   = sumar & ~restar & (r_count != CAP);
  assign w_over  = sumar & ~restar & (r_count == CAP);
  assign w_dec   = restar & ~sumar & (r_count != '0);
  assign w_under = restar & ~sumar & (r_count == '0);
  assign w_chg   = w_inc | w_dec;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      unique case (1'b1)
        w_inc:   r_count <= r_count + CNT_W'(1);
        w_dec:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // An over-capacity entry always reloads, so repeated attempts extend it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_alarm_tmr <= '0;
    end else if (w_over) begin
      r_alarm_tmr <= ALD;
    end else if (r_alarm_tmr != '0) begin
      r_alarm_tmr <= r_alarm_tmr - AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err_under <= 1'b0;
      r_err_over  <= 1'b0;
    end else begin
      r_err_under <= w_under | (r_err_under & ~err_clr);
      r_err_over  <= w_over  | (r_err_over  & ~err_clr);
    end
  end

  assign w_start = (r_count != r_last) | r_pending;
  assign w_last  = (r_bit_cnt == LST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_SHIFT;
      S_SHIFT: if (w_last)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load  = (r_state == S_IDLE) & w_start;
    w_shift = (r_state == S_SHIFT);
    w_done  = (r_state == S_DONE);
  end

  assign w_adj[3:0]  = (r_scr[3:0]  >= 4'd5) ? r_scr[3:0]  + 4'd3
                                             : r_scr[3:0];
  assign w_adj[7:4]  = (r_scr[7:4]  >= 4'd5) ? r_scr[7:4]  + 4'd3
                                             : r_scr[7:4];
  assign w_adj[11:8] = (r_scr[11:8] >= 4'd5) ? r_scr[11:8] + 4'd3
                                             : r_scr[11:8];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_snap    <= '0;
      r_shreg   <= '0;
      r_scr     <= '0;
      r_bit_cnt <= '0;
      r_last    <= '0;
      r_pending <= 1'b0;
      r_hund    <= '0;
      r_tens    <= '0;
      r_ones    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_load) begin
        r_snap    <= r_count;
        r_shreg   <= r_count;
        r_scr     <= '0;
        r_bit_cnt <= '0;
      end
      if (w_shift) begin
        r_shreg   <= r_shreg << 1;
        r_scr     <= (w_adj << 1) | {11'b0, r_shreg[CNT_W-1]};
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
      if (w_done) begin
        r_hund <= r_scr[11:8];
        r_tens <= r_scr[7:4];
        r_ones <= r_scr[3:0];
        r_last <= r_snap;
      end
      // A change mid-conversion forces another pass once this one lands.
      if (w_load) begin
        r_pending <= 1'b0;
      end else if (w_chg & (w_shift | w_done)) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign count     = r_count;
  assign full      = (r_count == CAP);
  assign empty     = (r_count == '0);
  assign alarm     = (r_alarm_tmr != '0);
  assign err_under = r_err_under;
  assign err_over  = r_err_over;
  assign bcd_hund  = r_hund;
  assign bcd_tens  = r_tens;
  assign bcd_ones  = r_ones;
  assign bcd_valid = r_valid;

endmodule

// File: tb/tb_occupancy_counter.sv
// Bench for occupancy_counter: scenario tasks plus a BCD strobe
// scoreboard that rejects wrong or unexpected display updates.
module tb_occupancy_counter;

  localparam int W   = 8;
  localparam int CAP = 99;
  localparam int AL  = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sumar = 1'b0;
  logic         restar = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] count;
  logic         full;
  logic         empty;
  logic         alarm;
  logic         err_under;
  logic         err_over;
  logic [3:0]   bcd_hund;
  logic [3:0]   bcd_tens;
  logic [3:0]   bcd_ones;
  logic         bcd_valid;

  int checks = 0;
  int errors = 0;
  logic [11:0] sb_q[$];
  bit sb_on = 1'b0;

  occupancy_counter #(
    .CNT_W(W),
    .CAPACITY(CAP),
    .ALARM_CYCLES(AL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sumar(sumar),
    .restar(restar),
    .err_clr(err_clr),
    .count(count),
    .full(full),
    .empty(empty),
    .alarm(alarm),
    .err_under(err_under),
    .err_over(err_over),
    .bcd_hund(bcd_hund),
    .bcd_tens(bcd_tens),
    .bcd_ones(bcd_ones),
    .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bcd_valid && sb_on) begin
      logic [11:0] exp;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_strobe got %h%h%h exp none",
                 bcd_hund, bcd_tens, bcd_ones);
      end else begin
        exp = sb_q.pop_front();
        if ({bcd_hund, bcd_tens, bcd_ones} !== exp) begin
          errors++;
          $display("FAIL strobe_digits got %h%h%h exp %h",
                   bcd_hund, bcd_tens, bcd_ones, exp);
        end
      end
    end
  end

  task automatic hold(input logic s, input logic r, input int n);
    sumar  = s;
    restar = r;
    repeat (n) @(negedge clk);
    sumar  = 1'b0;
    restar = 1'b0;
  endtask

  task automatic wait_bcd(input logic [11:0] exp);
    int k = 0;
    while ({bcd_hund, bcd_tens, bcd_ones} !== exp && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones} !== exp) begin
      errors++;
      $display("FAIL settle_bcd got %h%h%h exp %h",
               bcd_hund, bcd_tens, bcd_ones, exp);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending exp 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({count, full, empty, alarm, err_under, err_over} !== {8'd0, 5'b01000}) begin
      errors++;
      $display("FAIL reset_state got %0d/%b%b%b%b%b exp 0/01000",
               count, full, empty, alarm, err_under, err_over);
    end
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones, bcd_valid} !== 13'd0) begin
      errors++;
      $display("FAIL reset_bcd got %h%h%h v%b exp 000 v0",
               bcd_hund, bcd_tens, bcd_ones, bcd_valid);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count_up();
    sb_on = 1'b1;
    sb_q.push_back(12'h001);
    sb_q.push_back(12'h003);
    repeat (3) begin
      hold(1'b1, 1'b0, 1);
      @(negedge clk);
    end
    checks++;
    if (count !== 8'd3 || empty !== 1'b0) begin
      errors++;
      $display("FAIL count_up got %0d e%b exp 3 e0", count, empty);
    end
    wait_drain();
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones} !== 12'h003) begin
      errors++;
      $display("FAIL count_up_bcd got %h%h%h exp 003",
               bcd_hund, bcd_tens, bcd_ones);
    end
  endtask

  task automatic test_over_capacity();
    int n;
    sb_on = 1'b0;
    hold(1'b1, 1'b0, CAP - 3);
    checks++;
    if (count !== 8'(CAP) || full !== 1'b1 || err_over !== 1'b0) begin
      errors++;
      $display("FAIL fill got %0d f%b o%b exp %0d f1 o0",
               count, full, err_over, CAP);
    end
    wait_bcd(12'h099);
    sb_on = 1'b1;
    hold(1'b1, 1'b0, 1);
    checks++;
    if (count !== 8'(CAP) || !full || !err_over || !alarm) begin
      errors++;
      $display("FAIL over_entry got %0d f%b o%b a%b exp %0d f1 o1 a1",
               count, full, err_over, alarm, CAP);
    end
    n = 0;
    while (alarm && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== AL) begin
      errors++;
      $display("FAIL alarm_len got %0d exp %0d", n, AL);
    end
    hold(1'b1, 1'b0, 1);
    repeat (19) @(negedge clk);
    hold(1'b1, 1'b0, 1);
    n = 0;
    while (alarm && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== AL) begin
      errors++;
      $display("FAIL alarm_retrig got %0d exp %0d", n, AL);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_over !== 1'b0 || count !== 8'(CAP) || !full) begin
      errors++;
      $display("FAIL over_clr got o%b %0d f%b exp o0 %0d f1",
               err_over, count, full, CAP);
    end
  endtask

  task automatic test_underflow();
    sb_on = 1'b0;
    hold(1'b0, 1'b1, CAP);
    wait_bcd(12'h000);
    sb_on = 1'b1;
    hold(1'b0, 1'b1, 1);
    checks++;
    if (count !== 8'd0 || !err_under || !empty || err_over) begin
      errors++;
      $display("FAIL under got %0d u%b e%b o%b exp 0 u1 e1 o0",
               count, err_under, empty, err_over);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_under !== 1'b0) begin
      errors++;
      $display("FAIL under_clr got %b exp 0", err_under);
    end
    err_clr = 1'b1;
    restar  = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    restar  = 1'b0;
    checks++;
    if (err_under !== 1'b1 || count !== 8'd0) begin
      errors++;
      $display("FAIL under_set_wins got u%b %0d exp u1 0", err_under, count);
    end
  endtask

  task automatic test_simultaneous();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    sb_on = 1'b0;
    hold(1'b1, 1'b0, 5);
    wait_bcd(12'h005);
    sb_on = 1'b1;
    hold(1'b1, 1'b1, 1);
    repeat (15) @(negedge clk);
    checks++;
    if ({count, full, empty, alarm, err_under, err_over} !== {8'd5, 5'b00000}) begin
      errors++;
      $display("FAIL both got %0d/%b%b%b%b%b exp 5/00000",
               count, full, empty, alarm, err_under, err_over);
    end
  endtask

  task automatic test_back_to_back();
    sb_on = 1'b0;
    hold(1'b1, 1'b0, 36);
    wait_bcd(12'h041);
    sb_on = 1'b1;
    sb_q.push_back(12'h042);
    sb_q.push_back(12'h043);
    hold(1'b1, 1'b0, 1);
    @(negedge clk);
    hold(1'b1, 1'b0, 1);
    wait_drain();
    checks++;
    if (count !== 8'd43 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h043) begin
      errors++;
      $display("FAIL b2b got %0d %h%h%h exp 43 043",
               count, bcd_hund, bcd_tens, bcd_ones);
    end
  endtask

  task automatic test_reset_mid();
    sb_on = 1'b0;
    hold(1'b1, 1'b0, 13);
    wait_bcd(12'h056);
    sb_on = 1'b1;
    hold(1'b1, 1'b0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({count, full, empty, alarm, err_under, err_over} !== {8'd0, 5'b01000}) begin
      errors++;
      $display("FAIL mid_reset got %0d/%b%b%b%b%b exp 0/01000",
               count, full, empty, alarm, err_under, err_over);
    end
    checks++;
    if ({bcd_hund, bcd_tens, bcd_ones, bcd_valid} !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset_bcd got %h%h%h v%b exp 000 v0",
               bcd_hund, bcd_tens, bcd_ones, bcd_valid);
    end
    repeat (25) @(negedge clk);
    checks++;
    if (count !== 8'd0 || {bcd_hund, bcd_tens, bcd_ones} !== 12'h000) begin
      errors++;
      $display("FAIL post_reset got %0d %h%h%h exp 0 000",
               count, bcd_hund, bcd_tens, bcd_ones);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count_up();
    test_over_capacity();
    test_underflow();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
